alu_armv4_seq: RTL and testbench

- Parametrised, clocked successor of the team's combinational ARMv4 ALU.
- Adds registered NZCV flags with ARM-style conditional flag update (S bit).
- Adds EOR, ADC, SBC and an iterative shift-add MUL.
- Sits between the decode stage and writeback behind a valid/ready handshake on both sides; holds its result until writeback accepts it.

---
 rtl/alu_armv4_seq_if.sv | 32 +++
 rtl/alu_armv4_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_armv4_seq.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_armv4_seq_if.sv
// Decode/writeback bus of the sequential ARMv4 ALU: operation request side,
// result side and the registered NZCV flags.
interface alu_armv4_seq_if #(
    parameter int W = 32
);
    // Both sides use the same valid/ready rule. A transfer happens on a rising
    // edge where VALID and READY are both 1. A source holds VALID and its
    // payload stable until that edge. A sink may raise or lower READY freely.
    logic         IN_VALID;
    logic         IN_READY;
    logic [2:0]   ALU_C;
    logic         SET_F;
    logic [W-1:0] IN1;
    logic [W-1:0] IN2;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [W-1:0] OUT;
    logic         NF;
    logic         ZF;
    logic         CF;
    logic         VF;

    modport master (
        output IN_VALID, ALU_C, SET_F, IN1, IN2, OUT_READY,
        input  IN_READY, OUT_VALID, OUT, NF, ZF, CF, VF
    );

    modport slave (
        input  IN_VALID, ALU_C, SET_F, IN1, IN2, OUT_READY,
        output IN_READY, OUT_VALID, OUT, NF, ZF, CF, VF
    );
endinterface

// File: rtl/alu_armv4_seq.sv
// Clocked ARMv4 ALU: single-cycle ADD/SUB/AND/ORR/EOR/ADC/SBC, iterative
// shift-add MUL, registered NZCV flags with conditional (S bit) update.
module alu_armv4_seq #(
    parameter int W = 32
) (
    input  logic               CLK,
    input  logic               RST_N,
    alu_armv4_seq_if.slave     bus,
    output logic [1:0]         dbg_state_o
);
    localparam int CW = $clog2(W + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_EOR = 3'b100;
    localparam logic [2:0] OP_ADC = 3'b101;
    localparam logic [2:0] OP_SBC = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    out_q;
    logic            out_valid_q;
    logic            n_q, z_q, c_q, v_q;
    logic [W-1:0]    mul_a_q;
    logic [W-1:0]    mul_b_q;
    logic [W-1:0]    acc_q;
    logic [CW-1:0]   cnt_q;
    logic            mul_setf_q;

    logic            in_ready;
    logic            accept;
    logic            load_alu;
    logic            load_mul;

    logic            sub_op;
    logic            arith;
    logic            cin;
    logic [W-1:0]    b_eff;
    logic [W:0]      sum;
    logic [W-1:0]    alu_res;
    logic            alu_v;

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && bus.ALU_C == OP_MUL) state_d = S_MUL;
            S_MUL:   if (cnt_q == CW'(W - 1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; DONE needs no stall because IN_READY at MUL entry implied a drain
    always_comb begin
        in_ready = RST_N && (state_q == S_IDLE) && (!out_valid_q || bus.OUT_READY);
        accept   = bus.IN_VALID && in_ready;
        load_alu = accept && (bus.ALU_C != OP_MUL);
        load_mul = (state_q == S_DONE);
    end

    // Single-cycle datapath; SUB/SBC add the inverted operand
    always_comb begin
        sub_op = (bus.ALU_C == OP_SUB) || (bus.ALU_C == OP_SBC);
        arith  = (bus.ALU_C == OP_ADD) || (bus.ALU_C == OP_SUB) ||
                 (bus.ALU_C == OP_ADC) || (bus.ALU_C == OP_SBC);
        b_eff  = sub_op ? ~bus.IN2 : bus.IN2;
        case (bus.ALU_C)
            OP_SUB:          cin = 1'b1;
            OP_ADC, OP_SBC:  cin = c_q;
            default:         cin = 1'b0;
        endcase
        sum = {1'b0, bus.IN1} + {1'b0, b_eff} + {{W{1'b0}}, cin};
        case (bus.ALU_C)
            OP_AND:  alu_res = bus.IN1 & bus.IN2;
            OP_ORR:  alu_res = bus.IN1 | bus.IN2;
            OP_EOR:  alu_res = bus.IN1 ^ bus.IN2;
            OP_MUL:  alu_res = '0;
            default: alu_res = sum[W-1:0];
        endcase
        alu_v = (bus.IN1[W-1] == b_eff[W-1]) && (sum[W-1] != bus.IN1[W-1]);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            mul_setf_q  <= 1'b0;
        end else begin
            if (load_alu) begin
                out_q <= alu_res;
                if (bus.SET_F) begin
                    n_q <= alu_res[W-1];
                    z_q <= (alu_res == '0);
                    if (arith) begin
                        c_q <= sum[W];
                        v_q <= alu_v;
                    end
                end
            end else if (load_mul) begin
                out_q <= acc_q;
                if (mul_setf_q) begin
                    n_q <= acc_q[W-1];
                    z_q <= (acc_q == '0);
                end
            end

            if (load_alu || load_mul) begin
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.OUT_READY) begin
                out_valid_q <= 1'b0;
            end

            // Multiplicand shifts left and multiplier right, one bit per cycle
            if (accept && bus.ALU_C == OP_MUL) begin
                mul_a_q    <= bus.IN1;
                mul_b_q    <= bus.IN2;
                acc_q      <= '0;
                cnt_q      <= '0;
                mul_setf_q <= bus.SET_F;
            end else if (state_q == S_MUL) begin
                acc_q   <= acc_q + (mul_b_q[0] ? mul_a_q : '0);
                mul_a_q <= mul_a_q << 1;
                mul_b_q <= mul_b_q >> 1;
                cnt_q   <= cnt_q + CW'(1);
            end
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT       = out_q;
    assign bus.NF        = n_q;
    assign bus.ZF        = z_q;
    assign bus.CF        = c_q;
    assign bus.VF        = v_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_alu_armv4_seq.sv
// Bench for alu_armv4_seq: directed cases with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_alu_armv4_seq;
  localparam int W = 32;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [1:0] dbg_state;

  alu_armv4_seq_if #(.W(W)) bus ();

  alu_armv4_seq #(.W(W)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;
  bit rand_rdy = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: results from plain integer arithmetic, MUL as a countdown
  logic [W-1:0] m_out = '0;
  bit           m_valid = 0, m_n = 0, m_z = 0, m_c = 0, m_v = 0;
  int           m_busy = 0;
  logic [W-1:0] m_mres = '0;
  bit           m_mset = 0;
  logic [W-1:0] exp_q[$];

  function automatic bit m_ready();
    return RST_N && (m_busy == 0) && (!m_valid || bus.OUT_READY);
  endfunction

  always @(posedge CLK) begin : model
    longint ua, ub, sa, sb, tu, ts, cin, smax, smin;
    bit acc, dlv, ld, arith, cout;
    logic [W-1:0] r;
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    if (!RST_N) begin
      m_out = '0; m_valid = 0; m_n = 0; m_z = 0; m_c = 0; m_v = 0;
      m_busy = 0; exp_q.delete();
    end else begin
      acc = bus.IN_VALID && m_ready();
      dlv = m_valid && bus.OUT_READY;
      ld = 0;
      r = '0;
      if (dlv && exp_q.size() > 0) void'(exp_q.pop_front());
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          r = m_mres;
          ld = 1;
          if (m_mset) begin m_n = r[W-1]; m_z = (r == 0); end
        end
      end else if (acc) begin
        if (bus.ALU_C == 3'd7) begin
          m_mres = bus.IN1 * bus.IN2;
          m_mset = bus.SET_F;
          m_busy = W + 1;
        end else begin
          ua = longint'(bus.IN1); ub = longint'(bus.IN2);
          sa = longint'($signed(bus.IN1)); sb = longint'($signed(bus.IN2));
          cin = m_c ? 1 : 0;
          arith = 1; cout = 0; ts = 0; tu = 0;
          case (bus.ALU_C)
            3'd0: begin tu = ua + ub; ts = sa + sb; cout = tu >= (longint'(1) << W); end
            3'd1: begin tu = ua - ub; ts = sa - sb; cout = ua >= ub; end
            3'd5: begin tu = ua + ub + cin; ts = sa + sb + cin; cout = tu >= (longint'(1) << W); end
            3'd6: begin tu = ua - ub - (1 - cin); ts = sa - sb - (1 - cin); cout = ua >= ub + 1 - cin; end
            3'd2: begin tu = longint'(bus.IN1 & bus.IN2); arith = 0; end
            3'd3: begin tu = longint'(bus.IN1 | bus.IN2); arith = 0; end
            default: begin tu = longint'(bus.IN1 ^ bus.IN2); arith = 0; end
          endcase
          r = tu[W-1:0];
          ld = 1;
          if (bus.SET_F) begin
            m_n = r[W-1];
            m_z = (r == 0);
            if (arith) begin
              m_c = cout;
              m_v = (ts > smax) || (ts < smin);
            end
          end
        end
      end
      if (ld) begin
        m_out = r;
        m_valid = 1;
        exp_q.push_back(r);
      end else if (dlv) begin
        m_valid = 0;
      end
    end
  end

  // scoreboard / compare process
  always @(negedge CLK) begin
    if (cmp_on) begin
      check("in_ready", {{(W-1){1'b0}}, bus.IN_READY}, {{(W-1){1'b0}}, m_ready()});
      check("out_valid", {{(W-1){1'b0}}, bus.OUT_VALID}, {{(W-1){1'b0}}, m_valid});
      if (m_valid) check("out", bus.OUT, m_out);
      check("flags", {{(W-4){1'b0}}, bus.NF, bus.ZF, bus.CF, bus.VF},
            {{(W-4){1'b0}}, m_n, m_z, m_c, m_v});
      if (bus.OUT_VALID && bus.OUT_READY && exp_q.size() > 0)
        check("sb_deliver", bus.OUT, exp_q[0]);
    end
  end

  // random writeback backpressure
  always @(posedge CLK) begin
    #1;
    if (rand_rdy) bus.OUT_READY = ($urandom_range(0, 3) != 0);
  end

  // driver: present an op, wait (bounded) for acceptance; returns 1 after the accept edge
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    bit got = 0;
    bus.IN_VALID = 1'b1;
    bus.ALU_C = op;
    bus.IN1 = a;
    bus.IN2 = b;
    bus.SET_F = s;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (bus.IN_READY) begin got = 1; break; end
    end
    check("accept_timeout", {{(W-1){1'b0}}, got}, 1);
    @(posedge CLK);
    #1;
    bus.IN_VALID = 1'b0;
    bus.ALU_C = 3'($urandom_range(0, 7));
    bus.IN1 = $urandom;
    bus.IN2 = $urandom;
    bus.SET_F = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      default: return $urandom;
    endcase
  endfunction

  task automatic chk_flags(input string name, input logic [3:0] exp);
    check(name, {{(W-4){1'b0}}, bus.NF, bus.ZF, bus.CF, bus.VF}, {{(W-4){1'b0}}, exp});
  endtask

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    logic [2:0] op;
    bus.IN_VALID = 0; bus.ALU_C = 0; bus.SET_F = 0;
    bus.IN1 = 0; bus.IN2 = 0; bus.OUT_READY = 1;

    // reset
    RST_N = 0;
    @(posedge CLK); #1;
    cmp_on = 1;
    @(negedge CLK);
    check("rst_in_ready", {{(W-1){1'b0}}, bus.IN_READY}, 0);
    @(posedge CLK); #1;
    RST_N = 1;
    check("rst_out", bus.OUT, 0);
    check("rst_out_valid", {{(W-1){1'b0}}, bus.OUT_VALID}, 0);
    chk_flags("rst_flags", 4'b0000);

    // ADD overflow into sign bit
    do_op(3'd0, 32'h7FFFFFFF, 32'h00000001, 1);
    check("add_ovf_out", bus.OUT, 32'h80000000);
    check("add_ovf_valid", {{(W-1){1'b0}}, bus.OUT_VALID}, 1);
    chk_flags("add_ovf_flags", 4'b1001);

    // SUB then SBC back-to-back, SBC consumes C=1
    do_op(3'd1, 32'd5, 32'd5, 1);
    check("sub_out", bus.OUT, 0);
    chk_flags("sub_flags", 4'b0110);
    do_op(3'd6, 32'd0, 32'd0, 1);
    check("sbc_out", bus.OUT, 0);
    chk_flags("sbc_flags", 4'b0110);

    // ADD wrap, ADC without S, EOR with S
    do_op(3'd0, 32'hFFFFFFFF, 32'h1, 1);
    check("add_wrap_out", bus.OUT, 0);
    do_op(3'd5, 32'd0, 32'd0, 0);
    check("adc_out", bus.OUT, 32'd1);
    chk_flags("adc_flags_hold", 4'b0110);
    do_op(3'd4, 32'hF0F0F0F0, 32'hFFFFFFFF, 1);
    check("eor_out", bus.OUT, 32'h0F0F0F0F);
    chk_flags("eor_flags", 4'b0010);

    // MUL latency and result
    do_op(3'd7, 32'h00012345, 32'h00010000, 1);
    n = 0;
    while (n < 100) begin
      @(negedge CLK);
      if (bus.IN_READY) break;
      n++;
    end
    check("mul_busy_cycles", W'(n), 33);
    check("mul_out", bus.OUT, 32'h23450000);
    chk_flags("mul_flags", 4'b0010);
    @(posedge CLK); #1;

    // writeback backpressure, then drain and accept on the same edge
    bus.OUT_READY = 0;
    do_op(3'd0, 32'd1, 32'd1, 0);
    bus.IN_VALID = 1; bus.ALU_C = 3'd3; bus.IN1 = 32'h30; bus.IN2 = 32'h0C; bus.SET_F = 0;
    repeat (3) begin
      @(negedge CLK);
      check("bp_in_ready", {{(W-1){1'b0}}, bus.IN_READY}, 0);
      check("bp_out_stable", bus.OUT, 32'd2);
    end
    @(posedge CLK); #1;
    bus.OUT_READY = 1;
    @(negedge CLK);
    check("bp_release_ready", {{(W-1){1'b0}}, bus.IN_READY}, 1);
    @(posedge CLK); #1;
    bus.IN_VALID = 0;
    check("bp_new_out", bus.OUT, 32'h3C);
    check("bp_valid_kept", {{(W-1){1'b0}}, bus.OUT_VALID}, 1);

    // reset in the middle of a MUL
    do_op(3'd7, $urandom, $urandom, 1);
    repeat (8) @(posedge CLK);
    #1;
    RST_N = 0;
    @(negedge CLK);
    check("mulrst_in_ready", {{(W-1){1'b0}}, bus.IN_READY}, 0);
    @(posedge CLK); #1;
    check("mulrst_out", bus.OUT, 0);
    check("mulrst_valid", {{(W-1){1'b0}}, bus.OUT_VALID}, 0);
    chk_flags("mulrst_flags", 4'b0000);
    RST_N = 1;
    do_op(3'd0, 32'd2, 32'd3, 0);
    check("post_rst_add", bus.OUT, 32'd5);

    // randomized traffic against the model
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'd7 && $urandom_range(0, 3) != 0) op = 3'($urandom_range(0, 6));
      do_op(op, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
      if (i == 150) begin
        RST_N = 0;
        @(posedge CLK); #1;
        RST_N = 1;
      end
    end
    rand_rdy = 0;
    @(posedge CLK); #1;
    bus.OUT_READY = 1;
    repeat (40) @(posedge CLK);
    #1;
    check("drain_valid", {{(W-1){1'b0}}, bus.OUT_VALID}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
